// File: rtl/branch_resolve.sv
// Branch/jump resolution: evaluates condition, target and next PC; flags mispredicts and holds the IFU redirect.
// Latency: accept at N, result (done_o/flush_o) in cycle N+2; one request in flight.
// Backpressure: br_ready_o low outside IDLE; redirect held until redir_ready_i, kill_i or reset.
module branch_resolve (
    input  logic        clock,
    input  logic        reset,
    input  logic        br_valid_i,
    output logic        br_ready_o,
    input  logic [1:0]  br_kind_i,
    input  logic [2:0]  br_fn_i,
    input  logic [31:0] br_a_i,
    input  logic [31:0] br_b_i,
    input  logic [31:0] br_pc_i,
    input  logic [31:0] br_imm_i,
    input  logic [31:0] br_pred_pc_i,
    input  logic        kill_i,
    output logic        done_o,
    output logic [31:0] link_o,
    output logic        misalign_o,
    output logic        flush_o,
    output logic        redir_valid_o,
    input  logic        redir_ready_i,
    output logic [31:0] redir_pc_o,
    output logic [31:0] cnt_branch_o,
    output logic [31:0] cnt_mispred_o
);

    typedef enum logic [1:0] {IDLE, RESOLVE, RESP} state_t;

    state_t      state;
    logic [1:0]  kind_q;
    logic [2:0]  fn_q;
    logic [31:0] a_q, b_q, pc_q, imm_q, pred_q;

    logic [31:0] diff, target, seq_pc, next_pc;
    logic        diff_neg, cond, taken, misalign, mispred;

    assign br_ready_o = (state == IDLE);

    always_comb begin
        diff     = a_q - b_q;
        diff_neg = $signed(diff) < 0;
        cond     = 1'b0;
        case (fn_q)
            3'b000: cond = (a_q == b_q);
            3'b001: cond = (a_q != b_q);
            3'b010: cond = ($signed(a_q) >= $signed(b_q));
            3'b011: cond = ($signed(a_q) <  $signed(b_q));
            3'b100: cond = (a_q >  b_q);
            3'b101: cond = (a_q <  b_q);
            3'b110: cond = (a_q >= b_q);
            // overflow: operand signs differ and the result sign differs from a
            3'b111: cond = (a_q[31] ^ b_q[31]) & (a_q[31] ^ diff_neg);
            default: cond = 1'b0;
        endcase

        taken = 1'b0;
        case (kind_q)
            2'b00:   taken = cond;
            2'b01:   taken = 1'b1;
            2'b10:   taken = 1'b1;
            default: taken = 1'b0;
        endcase

        target   = (kind_q == 2'b10) ? ((a_q + imm_q) & ~32'h1) : (pc_q + imm_q);
        seq_pc   = pc_q + 32'd4;
        next_pc  = taken ? target : seq_pc;
        misalign = taken & target[1];
        mispred  = ~misalign & (next_pc != pred_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            kind_q        <= '0;
            fn_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            pc_q          <= '0;
            imm_q         <= '0;
            pred_q        <= '0;
            done_o        <= 1'b0;
            flush_o       <= 1'b0;
            misalign_o    <= 1'b0;
            redir_valid_o <= 1'b0;
            link_o        <= '0;
            redir_pc_o    <= '0;
            cnt_branch_o  <= '0;
            cnt_mispred_o <= '0;
        end else begin
            done_o  <= 1'b0;
            flush_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (br_valid_i) begin
                        kind_q <= br_kind_i;
                        fn_q   <= br_fn_i;
                        a_q    <= br_a_i;
                        b_q    <= br_b_i;
                        pc_q   <= br_pc_i;
                        imm_q  <= br_imm_i;
                        pred_q <= br_pred_pc_i;
                        state  <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (kill_i) begin
                        state <= IDLE;
                    end else begin
                        link_o        <= seq_pc;
                        redir_pc_o    <= next_pc;
                        misalign_o    <= misalign;
                        done_o        <= 1'b1;
                        flush_o       <= mispred;
                        redir_valid_o <= mispred;
                        cnt_branch_o  <= cnt_branch_o + 32'd1;
                        if (mispred)
                            cnt_mispred_o <= cnt_mispred_o + 32'd1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (kill_i || !redir_valid_o || redir_ready_i) begin
                        redir_valid_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed cases plus randomized requests against a rule-level reference model.
module tb_branch_resolve;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid_i = 1'b0;
    logic        br_ready_o;
    logic [1:0]  br_kind_i = '0;
    logic [2:0]  br_fn_i = '0;
    logic [31:0] br_a_i = '0, br_b_i = '0, br_pc_i = '0, br_imm_i = '0, br_pred_pc_i = '0;
    logic        kill_i = 1'b0;
    logic        done_o, misalign_o, flush_o, redir_valid_o;
    logic        redir_ready_i = 1'b0;
    logic [31:0] link_o, redir_pc_o, cnt_branch_o, cnt_mispred_o;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_cnt_br = '0;
    logic [31:0] m_cnt_mp = '0;

    always #5 clock = ~clock;

    branch_resolve dut (
        .clock(clock), .reset(reset),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
        .br_kind_i(br_kind_i), .br_fn_i(br_fn_i),
        .br_a_i(br_a_i), .br_b_i(br_b_i), .br_pc_i(br_pc_i),
        .br_imm_i(br_imm_i), .br_pred_pc_i(br_pred_pc_i),
        .kill_i(kill_i), .done_o(done_o), .link_o(link_o),
        .misalign_o(misalign_o), .flush_o(flush_o),
        .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i),
        .redir_pc_o(redir_pc_o),
        .cnt_branch_o(cnt_branch_o), .cnt_mispred_o(cnt_mispred_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: evaluates the architectural rules directly with wide signed arithmetic.
    task automatic model(input logic [1:0] k, input logic [2:0] f,
                         input logic [31:0] a, b, pc, imm, pred,
                         output logic [31:0] nxt, output logic mis, output logic misp);
        longint sa, sb, sd;
        longint unsigned ua, ub;
        logic c, tk;
        logic [31:0] tgt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sd = sa - sb;
        case (f)
            3'd0: c = (ua == ub);
            3'd1: c = (ua != ub);
            3'd2: c = (sa >= sb);
            3'd3: c = (sa < sb);
            3'd4: c = (ua > ub);
            3'd5: c = (ua < ub);
            3'd6: c = (ua >= ub);
            default: c = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        endcase
        tk  = (k == 2'd1) || (k == 2'd2) || (k == 2'd0 && c);
        tgt = (k == 2'd2) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        nxt = tk ? tgt : pc + 32'd4;
        mis = tk && tgt[1];
        misp = !mis && (nxt != pred);
    endtask

    task automatic accept(input logic [1:0] k, input logic [2:0] f,
                          input logic [31:0] a, b, pc, imm, pred);
        @(negedge clock);
        chk("ready_idle", {31'd0, br_ready_o}, 32'd1);
        br_kind_i = k; br_fn_i = f; br_a_i = a; br_b_i = b;
        br_pc_i = pc; br_imm_i = imm; br_pred_pc_i = pred;
        br_valid_i = 1'b1;
        @(posedge clock);
        #1 br_valid_i = 1'b0;
        br_a_i = $urandom; br_b_i = $urandom;
        @(negedge clock);
        chk("ready_resolve", {31'd0, br_ready_o}, 32'd0);
        chk("done_early", {31'd0, done_o}, 32'd0);
    endtask

    task automatic do_br(input logic [1:0] k, input logic [2:0] f,
                         input logic [31:0] a, b, pc, imm, pred, input int hold);
        logic [31:0] nxt;
        logic mis, misp;
        model(k, f, a, b, pc, imm, pred, nxt, mis, misp);
        accept(k, f, a, b, pc, imm, pred);
        @(negedge clock);
        m_cnt_br = m_cnt_br + 32'd1;
        if (misp) m_cnt_mp = m_cnt_mp + 32'd1;
        chk("done", {31'd0, done_o}, 32'd1);
        chk("flush", {31'd0, flush_o}, {31'd0, misp});
        chk("misalign", {31'd0, misalign_o}, {31'd0, mis});
        chk("link", link_o, pc + 32'd4);
        chk("redir_valid", {31'd0, redir_valid_o}, {31'd0, misp});
        chk("cnt_branch", cnt_branch_o, m_cnt_br);
        chk("cnt_mispred", cnt_mispred_o, m_cnt_mp);
        if (misp) begin
            chk("redir_pc", redir_pc_o, nxt);
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                chk("redir_hold_valid", {31'd0, redir_valid_o}, 32'd1);
                chk("redir_hold_pc", redir_pc_o, nxt);
                chk("done_single", {31'd0, done_o | flush_o}, 32'd0);
            end
            redir_ready_i = 1'b1;
            @(posedge clock);
            #1 redir_ready_i = 1'b0;
        end
        @(negedge clock);
        chk("back_idle", {31'd0, br_ready_o}, 32'd1);
        chk("redir_clear", {31'd0, redir_valid_o}, 32'd0);
        chk("done_clear", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        logic [1:0]  k;
        logic [2:0]  f;
        logic [31:0] a, b, pc, imm, pred, nxt;
        logic        mis, misp;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", {31'd0, br_ready_o}, 32'd1);
        chk("rst_pulses", {28'd0, done_o, flush_o, misalign_o, redir_valid_o}, 32'd0);
        chk("rst_link", link_o, 32'd0);
        chk("rst_redir_pc", redir_pc_o, 32'd0);
        chk("rst_cnt_branch", cnt_branch_o, 32'd0);
        chk("rst_cnt_mispred", cnt_mispred_o, 32'd0);

        do_br(2'd0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 32'h120, 0);
        do_br(2'd0, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 32'h204, 3);
        do_br(2'd2, 3'd0, 32'h1003, 32'd0, 32'h800, 32'd0, 32'h1000, 0);
        do_br(2'd0, 3'd4, 32'h8000_0000, 32'd1, 32'h300, 32'h10, 32'h304, 0);
        do_br(2'd0, 3'd3, 32'h8000_0000, 32'd1, 32'h300, 32'h10, 32'h310, 0);
        do_br(2'd0, 3'd7, 32'h8000_0000, 32'd1, 32'h300, 32'h10, 32'h304, 1);
        do_br(2'd3, 3'd0, 32'd7, 32'd7, 32'h400, 32'h80, 32'h480, 0);
        do_br(2'd1, 3'd0, 32'd0, 32'd0, 32'h500, 32'hFFFF_FFF0, 32'h4F0, 0);

        // Kill while resolving: nothing may be reported.
        accept(2'd1, 3'd0, 32'd0, 32'd0, 32'h600, 32'h40, 32'h0);
        kill_i = 1'b1;
        @(posedge clock);
        #1 kill_i = 1'b0;
        @(negedge clock);
        chk("kill_resolve_done", {31'd0, done_o}, 32'd0);
        chk("kill_resolve_ready", {31'd0, br_ready_o}, 32'd1);
        chk("kill_resolve_cnt", cnt_branch_o, m_cnt_br);
        @(negedge clock);
        chk("kill_resolve_done2", {31'd0, done_o | redir_valid_o}, 32'd0);

        // Kill while a redirect is being held.
        accept(2'd1, 3'd0, 32'd0, 32'd0, 32'h700, 32'h40, 32'h704);
        @(negedge clock);
        m_cnt_br = m_cnt_br + 32'd1;
        m_cnt_mp = m_cnt_mp + 32'd1;
        chk("kill_resp_valid", {31'd0, redir_valid_o}, 32'd1);
        @(negedge clock);
        kill_i = 1'b1;
        @(posedge clock);
        #1 kill_i = 1'b0;
        @(negedge clock);
        chk("kill_resp_drop", {31'd0, redir_valid_o}, 32'd0);
        chk("kill_resp_ready", {31'd0, br_ready_o}, 32'd1);
        chk("kill_resp_cnt_mp", cnt_mispred_o, m_cnt_mp);

        for (int n = 0; n < 40; n++) begin
            k   = 2'($urandom_range(0, 3));
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            model(k, f, a, b, pc, imm, 32'd0, nxt, mis, misp);
            case ($urandom_range(0, 2))
                0: pred = nxt;
                1: pred = pc + 32'd4;
                default: pred = $urandom;
            endcase
            do_br(k, f, a, b, pc, imm, pred, $urandom_range(0, 2));
        end

        // Reset during RESP clears everything without a further pulse.
        accept(2'd0, 3'd1, 32'd1, 32'd2, 32'h900, 32'h20, 32'h904);
        @(negedge clock);
        chk("pre_reset_done", {31'd0, done_o}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        m_cnt_br = '0;
        m_cnt_mp = '0;
        @(negedge clock);
        chk("mid_rst_ready", {31'd0, br_ready_o}, 32'd1);
        chk("mid_rst_pulses", {28'd0, done_o, flush_o, misalign_o, redir_valid_o}, 32'd0);
        chk("mid_rst_link", link_o, 32'd0);
        chk("mid_rst_redir_pc", redir_pc_o, 32'd0);
        chk("mid_rst_cnt_branch", cnt_branch_o, m_cnt_br);
        chk("mid_rst_cnt_mispred", cnt_mispred_o, m_cnt_mp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
